// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one 8-bit ALU (dkgp8) between two requesters.
// The arbiter is round-robin, or fixed priority to requester 0 when FIXED_PRIO=1.
// Operands and results are registered, and valid/ready is used on both request
// and response. Only one operation is in flight at a time (IDLE -> EXEC -> RESP).
// Optional feature: define ALU_ARB_STATS_EN to add saturating per-requester
// grant counters (gnt0_cnt, gnt1_cnt) of width STATS_W.

module dkgp8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] sel,
    output logic [7:0] result,
    output logic       cout
);
    logic [8:0] sum;

    // ADD for sel[2]=0 (carry-in fixed at 0), otherwise a carry-less logic op
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[7:0];
        cout   = sum[8];
        if (sel[2]) begin
            cout = 1'b0;
            case (sel[1:0])
                2'b00:   result = a & b;
                2'b01:   result = a | b;
                2'b10:   result = a ^ b;
                default: result = ~a;
            endcase
        end
    end
endmodule

module alu_rr_arbiter #(
    parameter int FIXED_PRIO = 0
`ifdef ALU_ARB_STATS_EN
    , parameter int STATS_W  = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_result,
    output logic       rsp0_cout,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_result,
    output logic       rsp1_cout,
    output logic       busy
`ifdef ALU_ARB_STATS_EN
    , output logic [STATS_W-1:0] gnt0_cnt
    , output logic [STATS_W-1:0] gnt1_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] op_sel;
    logic       owner;
    logic       last_gnt;
    logic       pick_id;
    logic       accept;
    logic [7:0] alu_result;
    logic       alu_cout;

    dkgp8 u_alu (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Pick a requester: on a tie use fixed priority or the one not granted last
    always_comb begin
        pick_id = req1_valid;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) pick_id = 1'b0;
            else                 pick_id = ~last_gnt;
        end
    end

    // Readies are only offered in IDLE; a reset cycle never counts as a handshake
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !pick_id;
    assign req1_ready = (state == IDLE) && !rst && req1_valid && pick_id;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Transaction FSM: capture operands, execute for one cycle, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_sel      <= '0;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;
            busy        <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
            rsp0_cout   <= 1'b0;
            rsp1_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= pick_id ? req1_a   : req0_a;
                        op_b   <= pick_id ? req1_b   : req0_b;
                        op_sel <= pick_id ? req1_sel : req0_sel;
                        owner  <= pick_id;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_result <= alu_result;
                        rsp1_cout   <= alu_cout;
                        rsp1_valid  <= 1'b1;
                    end else begin
                        rsp0_result <= alu_result;
                        rsp0_cout   <= alu_cout;
                        rsp0_valid  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner ? rsp1_ready : rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        last_gnt   <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating count of accepted requests per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (accept) begin
            if (!pick_id && (gnt0_cnt != {STATS_W{1'b1}}))
                gnt0_cnt <= gnt0_cnt + {{(STATS_W-1){1'b0}}, 1'b1};
            if (pick_id && (gnt1_cnt != {STATS_W{1'b1}}))
                gnt1_cnt <= gnt1_cnt + {{(STATS_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a round-robin instance (k=0) and a fixed-priority
// instance (k=1) share one stimulus. A transaction-level model predicts every
// output on each cycle, and literal checks pin the model to known answers.
// With ALU_ARB_STATS_EN defined, the grant counters are also checked
// (STATS_W=16 on k=0 and 2 on k=1).

module tb_alu_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] v   = 2'b00;
    logic [1:0] rr  = 2'b11;
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [2:0] s [2];

    logic       rdy [2][2];
    logic       rv  [2][2];
    logic [7:0] res [2][2];
    logic       co  [2][2];
    logic       bsy [2];
`ifdef ALU_ARB_STATS_EN
    logic [15:0] c0_k0, c1_k0;
    logic [1:0]  c0_k1, c1_k1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int glog0[$];
    int glog1[$];

    always #5 clk = ~clk;

    alu_rr_arbiter #(.FIXED_PRIO(0)
`ifdef ALU_ARB_STATS_EN
        , .STATS_W(16)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(rdy[0][0]), .req0_a(a[0]), .req0_b(b[0]), .req0_sel(s[0]),
        .rsp0_valid(rv[0][0]), .rsp0_ready(rr[0]), .rsp0_result(res[0][0]), .rsp0_cout(co[0][0]),
        .req1_valid(v[1]), .req1_ready(rdy[0][1]), .req1_a(a[1]), .req1_b(b[1]), .req1_sel(s[1]),
        .rsp1_valid(rv[0][1]), .rsp1_ready(rr[1]), .rsp1_result(res[0][1]), .rsp1_cout(co[0][1]),
        .busy(bsy[0])
`ifdef ALU_ARB_STATS_EN
        , .gnt0_cnt(c0_k0), .gnt1_cnt(c1_k0)
`endif
    );

    alu_rr_arbiter #(.FIXED_PRIO(1)
`ifdef ALU_ARB_STATS_EN
        , .STATS_W(2)
`endif
    ) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(rdy[1][0]), .req0_a(a[0]), .req0_b(b[0]), .req0_sel(s[0]),
        .rsp0_valid(rv[1][0]), .rsp0_ready(rr[0]), .rsp0_result(res[1][0]), .rsp0_cout(co[1][0]),
        .req1_valid(v[1]), .req1_ready(rdy[1][1]), .req1_a(a[1]), .req1_b(b[1]), .req1_sel(s[1]),
        .rsp1_valid(rv[1][1]), .rsp1_ready(rr[1]), .rsp1_result(res[1][1]), .rsp1_cout(co[1][1]),
        .busy(bsy[1])
`ifdef ALU_ARB_STATS_EN
        , .gnt0_cnt(c0_k1), .gnt1_cnt(c1_k1)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit         m_pend  [2] = '{0, 0};
    int         m_owner [2] = '{0, 0};
    int         m_stage [2] = '{0, 0};
    int         m_last  [2] = '{1, 1};
    logic [8:0] m_pres  [2];
    logic [7:0] m_res   [2][2];
    logic       m_co    [2][2];
    int         m_cnt   [2][2];

    function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [2:0] sel);
        if (!sel[2]) return {1'b0, x} + {1'b0, y};
        case (sel[1:0])
            2'd0:    return {1'b0, x & y};
            2'd1:    return {1'b0, x | y};
            2'd2:    return {1'b0, x ^ y};
            default: return {1'b0, ~x};
        endcase
    endfunction

    function automatic int pick(input int k);
        if (v[0] && v[1]) return (k == 1) ? 0 : ((m_last[k] == 0) ? 1 : 0);
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = 0;
                m_last[k] = 1;
                for (int i = 0; i < 2; i++) begin
                    m_res[k][i] = 8'h00;
                    m_co[k][i]  = 1'b0;
                    m_cnt[k][i] = 0;
                end
            end else if (!m_pend[k]) begin
                int p;
                p = pick(k);
                if (p >= 0) begin
                    m_pend[k]  = 1;
                    m_owner[k] = p;
                    m_stage[k] = 0;
                    m_pres[k]  = alu_f(a[p], b[p], s[p]);
                    if (m_cnt[k][p] < cmax(k)) m_cnt[k][p]++;
                end
            end else if (m_stage[k] == 0) begin
                m_res[k][m_owner[k]] = m_pres[k][7:0];
                m_co[k][m_owner[k]]  = m_pres[k][8];
                m_stage[k] = 1;
            end else if (rr[m_owner[k]]) begin
                m_last[k] = m_owner[k];
                m_pend[k] = 0;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < 2; k++) begin
                int p;
                p = pick(k);
                chk($sformatf("busy k%0d", k), bsy[k], m_pend[k]);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("req_ready k%0d r%0d", k, i), rdy[k][i], (!m_pend[k] && p == i) ? 1 : 0);
                    chk($sformatf("rsp_valid k%0d r%0d", k, i), rv[k][i],
                        (m_pend[k] && m_stage[k] == 1 && m_owner[k] == i) ? 1 : 0);
                    chk($sformatf("result k%0d r%0d", k, i), res[k][i], m_res[k][i]);
                    chk($sformatf("cout k%0d r%0d", k, i), co[k][i], m_co[k][i]);
                end
            end
`ifdef ALU_ARB_STATS_EN
            chk("gnt0_cnt k0", c0_k0, m_cnt[0][0]);
            chk("gnt1_cnt k0", c1_k0, m_cnt[0][1]);
            chk("gnt0_cnt k1", c0_k1, m_cnt[1][0]);
            chk("gnt1_cnt k1", c1_k1, m_cnt[1][1]);
`endif
        end
    end

    // grant order log (handshake visible at the negedge before the accepting edge)
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] && rdy[0][i]) glog0.push_back(i);
                if (v[i] && rdy[1][i]) glog1.push_back(i);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready(input int i);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rdy[0][i]) break;
            n++;
            if (n > 20) begin
                chk($sformatf("timeout ready r%0d", i), 0, 1);
                break;
            end
        end
    endtask

    task automatic do_op(input int i, input logic [7:0] x, input logic [7:0] y, input logic [2:0] sel);
        a[i] = x; b[i] = y; s[i] = sel; v[i] = 1'b1;
        wait_ready(i);
        @(posedge clk); #1;
        v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin a[i] = 0; b[i] = 0; s[i] = 0; end
        do_reset();
        chk_en = 1;
        @(negedge clk);
        chk("reset busy", bsy[0], 0);
        chk("reset rsp0_valid", rv[0][0], 0);
        chk("reset rsp0_result", res[0][0], 0);
        chk("reset req1_ready", rdy[0][1], 0);
        @(posedge clk); #1;

        // 1: ADD with carry out
        do_op(0, 8'hFF, 8'h01, 3'b000);
        chk("t1 rsp0_result", res[0][0], 8'h00);
        chk("t1 rsp0_cout", co[0][0], 1);
        chk("t1 rsp1_result untouched", res[0][1], 0);

        // 2: logic ops from requester 1
        do_op(1, 8'hF0, 8'h3C, 3'b110);
        chk("t2 xor", res[0][1], 8'hCC);
        chk("t2 xor cout", co[0][1], 0);
        do_op(1, 8'hF0, 8'h3C, 3'b111);
        chk("t2 not", res[0][1], 8'h0F);
        do_op(1, 8'hF0, 8'h3C, 3'b100);
        chk("t2 and", res[0][1], 8'h30);

        // 4: response back-pressure while requester 1 waits
        rr[0] = 1'b0;
        a[1] = 8'h55; b[1] = 8'h0F; s[1] = 3'b101; v[1] = 1'b1;
        a[0] = 8'h12; b[0] = 8'h34; s[0] = 3'b000; v[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1 v[0] = 1'b0;
        begin
            int n = 0;
            forever begin
                @(negedge clk);
                if (rv[0][0]) break;
                n++;
                if (n > 10) begin chk("t4 timeout rsp0_valid", 0, 1); break; end
            end
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("t4 rsp0_valid held", rv[0][0], 1);
            chk("t4 result stable", res[0][0], 8'h46);
            chk("t4 req1_ready low", rdy[0][1], 0);
            chk("t4 busy", bsy[0], 1);
        end
        @(posedge clk); #1 rr[0] = 1'b1;
        wait_ready(1);
        @(posedge clk); #1 v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4 queued req1 result", res[0][1], 8'h5F);

        // 5: reset during EXEC drops the op and restores the tie pointer
        a[0] = 8'h01; b[0] = 8'h02; s[0] = 3'b000; v[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1 v[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5 busy", bsy[0], 0);
        chk("t5 rsp0_result", res[0][0], 0);
        chk("t5 rsp1_result", res[0][1], 0);
        repeat (3) @(negedge clk);
        chk("t5 no rsp0_valid", rv[0][0], 0);
        @(posedge clk); #1;
        glog0.delete(); glog1.delete();
        v = 2'b11;
        wait_ready(0);
        @(posedge clk); #1 v = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("t5 tie after reset", (glog0.size() > 0) ? glog0[0] : -1, 0);

        // 3: both valid from reset release, four ops
        rst = 1'b1;
        a[0] = 8'h10; b[0] = 8'h01; s[0] = 3'b001;
        a[1] = 8'hAA; b[1] = 8'h0F; s[1] = 3'b100;
        v = 2'b11;
        repeat (2) @(posedge clk);
        glog0.delete(); glog1.delete();
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1 v = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3 rr grant %0d", j), (glog0.size() > j) ? glog0[j] : -1, j % 2);
            chk($sformatf("t3 fp grant %0d", j), (glog1.size() > j) ? glog1[j] : -1, 0);
        end

`ifdef ALU_ARB_STATS_EN
        // 6: grant counters, including saturation on the 2-bit instance
        do_reset();
        for (int j = 0; j < 3; j++) do_op(0, 8'h01, 8'h01, 3'b000);
        for (int j = 0; j < 2; j++) do_op(1, 8'h02, 8'h02, 3'b101);
        chk("t6 gnt0_cnt", c0_k0, 3);
        chk("t6 gnt1_cnt", c1_k0, 2);
        for (int j = 0; j < 2; j++) do_op(0, 8'h03, 8'h01, 3'b000);
        chk("t6 gnt0_cnt 16b", c0_k0, 5);
        chk("t6 gnt0_cnt saturated", c0_k1, 3);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
